// File: rtl/fetch_stage_if.sv
// fetch_stage_if: hazard/redirect controls, instruction memory link and IF/ID outputs of the fetch stage.
// master = fetch stage side, slave = surrounding pipeline side.
interface fetch_stage_if;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] pc;
   logic [31:0] instruction;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
   logic        if_id_valid;
   modport master (
      input  stall, redirect, redirect_target, instruction,
      output pc, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid
   );
   modport slave (
      output stall, redirect, redirect_target, instruction,
      input  pc, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, instruction fetch and IF/ID register with stall and redirect/flush.
// Define FETCH_PERF_CNT_EN to add fetch/stall/flush performance counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic               clk,
   input  logic               rst,
   fetch_stage_if.master      bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]        fetch_count,
   output logic [31:0]        stall_count,
   output logic [31:0]        flush_count
`endif
);
   logic [31:0] pc_q, instr_q, ipc_q, ipc4_q, pc_plus4;
   logic        valid_q;
   assign pc_plus4           = pc_q + 32'd4;
   assign bus.pc             = pc_q;
   assign bus.if_id_instr    = instr_q;
   assign bus.if_id_pc       = ipc_q;
   assign bus.if_id_pc_plus4 = ipc4_q;
   assign bus.if_id_valid    = valid_q;
   // a redirect discards the word fetched this cycle but keeps the old IF/ID PCs
   always_ff @(posedge clk)
      if (rst) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         ipc_q   <= '0;
         ipc4_q  <= '0;
         valid_q <= 1'b0;
      end else if (bus.redirect) begin
         pc_q    <= {bus.redirect_target[31:2], 2'b00};
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end else if (!bus.stall) begin
         pc_q    <= pc_plus4;
         instr_q <= bus.instruction;
         ipc_q   <= pc_q;
         ipc4_q  <= pc_plus4;
         valid_q <= 1'b1;
      end
`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk)
      if (rst) begin
         fetch_count <= '0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         fetch_count <= fetch_count + {31'd0, !bus.redirect && !bus.stall};
         stall_count <= stall_count + {31'd0, !bus.redirect && bus.stall};
         flush_count <= flush_count + {31'd0, bus.redirect};
      end
`endif
endmodule
